// File: rtl/sc64.sv
// Shared SC64 definitions: CPU bus device ids, build options and bus router defaults.
package sc64;

    typedef enum logic [3:0] {
        ID_CPU_RAM,
        ID_CPU_FLASH,
        ID_CPU_GPIO,
        ID_CPU_I2C,
        ID_CPU_USB,
        ID_CPU_UART,
        ID_CPU_DMA,
        ID_CPU_CFG,
        ID_CPU_SDRAM,
        ID_CPU_FLASHRAM,
        ID_CPU_SI,
        ID_CPU_DD,
        __ID_CPU_END
    } e_cpu_id;

`ifdef DEBUG
    localparam bit CPU_HAS_UART = 1'b1;
`else
    localparam bit CPU_HAS_UART = 1'b0;
`endif

    localparam logic [31:0] CPU_RESET_VECTOR = 32'h1003_5800;
    localparam int          CPU_BUS_TIMEOUT  = 1024;

    // UART port is masked off in builds without the debug UART.
    localparam logic [11:0] CPU_DEV_ENABLE = 12'hFFF & ~(12'(!CPU_HAS_UART) << ID_CPU_UART);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } e_cpu_bus_state;

endpackage

// File: rtl/cpu_bus_router.sv
// Single-master CPU bus router: decodes address[31:28] to one device port, waits for its ack
// or a timeout, and returns a one-cycle registered response (ack/error/rdata) to the CPU.
module cpu_bus_router
    import sc64::*;
#(
    parameter int                     NUM_DEVICES    = int'(__ID_CPU_END),
    parameter int                     TIMEOUT_CYCLES = CPU_BUS_TIMEOUT,
    parameter logic [NUM_DEVICES-1:0] DEV_ENABLE     = CPU_DEV_ENABLE
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [3:0]                  cpu_wmask,
    input  logic [31:0]                 cpu_address,
    input  logic [31:0]                 cpu_wdata,
    output logic                        cpu_ack,
    output logic                        cpu_error,
    output logic [31:0]                 cpu_rdata,

    output logic [NUM_DEVICES-1:0]      dev_req,
    output logic                        dev_we,
    output logic [3:0]                  dev_wmask,
    output logic [27:0]                 dev_address,
    output logic [31:0]                 dev_wdata,
    input  logic [NUM_DEVICES-1:0]      dev_ack,
    input  logic [NUM_DEVICES-1:0][31:0] dev_rdata
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    e_cpu_bus_state         r_state;
    e_cpu_bus_state         w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [NUM_DEVICES-1:0] r_dev_req;
    logic [NUM_DEVICES-1:0] w_dev_req_next;
    logic [NUM_DEVICES-1:0] w_decode;
    logic                   w_sel_ack;
    logic [31:0]            w_sel_rdata;
    logic                   w_resp;
    logic                   w_resp_err;
    logic [31:0]            w_resp_rdata;

    logic                   r_we;
    logic [3:0]             r_wmask;
    logic [27:0]            r_address;
    logic [31:0]            r_wdata;
    logic                   r_cpu_ack;
    logic                   r_cpu_error;
    logic [31:0]            r_cpu_rdata;

    // One-hot target; empty when the id is out of range or the port is disabled.
    always_comb begin
        w_decode = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            if (cpu_address[31:28] == 4'(i) && DEV_ENABLE[i]) begin
                w_decode[i] = 1'b1;
            end
        end
    end

    // Only the selected device can complete the access; stray acks are masked out.
    always_comb begin
        w_sel_ack   = |(dev_ack & r_dev_req);
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            w_sel_rdata = w_sel_rdata | (dev_rdata[i] & {32{r_dev_req[i]}});
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_dev_req_next = r_dev_req;
        w_resp         = 1'b0;
        w_resp_err     = 1'b0;
        w_resp_rdata   = '0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    if (|w_decode) begin
                        w_state_next   = S_WAIT;
                        w_dev_req_next = w_decode;
                        w_cnt_next     = '0;
                    end else begin
                        w_state_next = S_RESP;
                        w_resp       = 1'b1;
                        w_resp_err   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Ack is tested first so an ack on the expiry cycle still succeeds.
                if (w_sel_ack) begin
                    w_state_next   = S_RESP;
                    w_dev_req_next = '0;
                    w_resp         = 1'b1;
                    w_resp_rdata   = r_we ? 32'h0 : w_sel_rdata;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_next   = S_RESP;
                    w_dev_req_next = '0;
                    w_resp         = 1'b1;
                    w_resp_err     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next   = S_IDLE;
                w_dev_req_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dev_req   <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_error <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_dev_req   <= w_dev_req_next;
            r_cpu_ack   <= w_resp;
            r_cpu_error <= w_resp_err;
            r_cpu_rdata <= w_resp_rdata;
        end
    end

    // Request fields are captured once per accepted access and held for the device.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we      <= 1'b0;
            r_wmask   <= '0;
            r_address <= '0;
            r_wdata   <= '0;
        end else if (r_state == S_IDLE && cpu_req) begin
            r_we      <= cpu_we;
            r_wmask   <= cpu_wmask;
            r_address <= cpu_address[27:0];
            r_wdata   <= cpu_wdata;
        end
    end

    assign cpu_ack     = r_cpu_ack;
    assign cpu_error   = r_cpu_error;
    assign cpu_rdata   = r_cpu_rdata;
    assign dev_req     = r_dev_req;
    assign dev_we      = r_we;
    assign dev_wmask   = r_wmask;
    assign dev_address = r_address;
    assign dev_wdata   = r_wdata;

endmodule
